// File: rtl/uart_12bit_pack_qpsk.sv
// uart_12bit_pack_qpsk: header-locked UART byte stream packer producing 12-bit QPSK sample pairs
module uart_12bit_pack_qpsk #(
  parameter int PAIR_NUM = 10000,
  parameter int TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR0 = 8'h55,
  parameter logic [7:0] HDR1 = 8'hAA
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic uart_rev_12_valid,
  output logic [11:0] uart_rev_12_a,
  output logic [11:0] uart_rev_12_b,
  output logic [15:0] pair_cnt,
  output logic pack_busy,
  output logic frame_done,
  output logic frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, HDR2, B0, B1, B2, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic [7:0] byte0, byte1;
  logic active, timeout, lock, emit, last;
  assign active = state inside {HDR2, B0, B1, B2};
  assign timeout = active && !uart_rx_done && tcnt == TW'(TIMEOUT_CYC - 1);
  assign lock = state == HDR2 && uart_rx_done && uart_rx_data == HDR1;
  assign emit = state == B2 && uart_rx_done;
  assign last = pair_cnt + 16'd1 == 16'(PAIR_NUM);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // A byte arriving on the timeout cycle wins: timeout already excludes uart_rx_done
  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (uart_rx_done)
      case (state)
        IDLE: state_n = uart_rx_data == HDR0 ? HDR2 : IDLE;
        HDR2: state_n = lock ? B0 : uart_rx_data == HDR0 ? HDR2 : IDLE;
        B0: state_n = B1;
        B1: state_n = B2;
        B2: state_n = last ? DONE : B0;
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      byte0 <= '0;
      byte1 <= '0;
      uart_rev_12_valid <= 1'b0;
      uart_rev_12_a <= '0;
      uart_rev_12_b <= '0;
      pair_cnt <= '0;
      pack_busy <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      uart_rev_12_valid <= 1'b0;
      frame_err <= timeout;
      tcnt <= (active && !uart_rx_done && !timeout) ? tcnt + 1'b1 : '0;
      if (lock) begin
        pair_cnt <= '0;
        pack_busy <= 1'b1;
      end
      if (state == B0 && uart_rx_done) byte0 <= uart_rx_data;
      if (state == B1 && uart_rx_done) byte1 <= uart_rx_data;
      if (emit) begin
        uart_rev_12_a <= {byte0, byte1[7:4]};
        uart_rev_12_b <= {byte1[3:0], uart_rx_data};
        uart_rev_12_valid <= 1'b1;
        pair_cnt <= pair_cnt == 16'(PAIR_NUM) ? pair_cnt : pair_cnt + 16'd1;
        if (last) begin
          frame_done <= 1'b1;
          pack_busy <= 1'b0;
        end
      end
      if (timeout) begin
        pack_busy <= 1'b0;
        byte0 <= '0;
        byte1 <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_12bit_pack_qpsk.sv
// tb_uart_12bit_pack_qpsk: directed scoreboard bench for the 12-bit pair packer
module tb_uart_12bit_pack_qpsk;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx_done = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic uart_rev_12_valid;
  logic [11:0] uart_rev_12_a, uart_rev_12_b;
  logic [15:0] pair_cnt;
  logic pack_busy, frame_done, frame_err;
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [23:0] exp_q[$];

  uart_12bit_pack_qpsk #(.PAIR_NUM(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx_done(uart_rx_done),
    .uart_rx_data(uart_rx_data),
    .uart_rev_12_valid(uart_rev_12_valid),
    .uart_rev_12_a(uart_rev_12_a),
    .uart_rev_12_b(uart_rev_12_b),
    .pair_cnt(pair_cnt),
    .pack_busy(pack_busy),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (uart_rev_12_valid) begin
      check("valid_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("pair", {uart_rev_12_a, uart_rev_12_b}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    tick();
    uart_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {uart_rev_12_valid, uart_rev_12_a, uart_rev_12_b, pair_cnt, pack_busy, frame_done, frame_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, i;
    logic found;
    logic [7:0] d0, d1, d2;
    tick();
    do_reset();
    check_zero("reset_outputs");

    // header lock and first pair
    send(8'h55); send(8'hAA); send(8'h12); send(8'h34);
    exp_q.push_back({12'h123, 12'h456});
    send(8'h56);
    check("lock_valid", uart_rev_12_valid, 1);
    check("lock_a", uart_rev_12_a, 12'h123);
    check("lock_b", uart_rev_12_b, 12'h456);
    check("lock_cnt", pair_cnt, 1);
    check("lock_busy", pack_busy, 1);
    tick();
    check("valid_one_cycle", uart_rev_12_valid, 0);
    check("hold_a", uart_rev_12_a, 12'h123);
    do_reset();

    // junk, false header, then header bytes used as data
    send(8'h33); send(8'hAA); idle(2);
    check("junk_busy", pack_busy, 0);
    send(8'h55); send(8'h55); send(8'hAA); send(8'hAB); send(8'hCD);
    exp_q.push_back({12'hABC, 12'hDEF});
    send(8'hEF);
    check("false_hdr_cnt", pair_cnt, 1);
    send(8'h55); send(8'hAA);
    exp_q.push_back({12'h55A, 12'hA55});
    send(8'h55);
    check("hdr_as_data_cnt", pair_cnt, 2);
    check("hdr_as_data_busy", pack_busy, 1);
    idle(1);
    check("pending_pairs_a", exp_q.size(), 0);
    do_reset();

    // full frame back-to-back, then ignored trailing bytes
    e0 = err_seen;
    send(8'h55); send(8'hAA);
    for (int k = 0; k < 4; k++) begin
      d0 = 8'(3 * k + 1); d1 = 8'(3 * k + 2); d2 = 8'(3 * k + 3);
      exp_q.push_back({d0, d1[7:4], d1[3:0], d2});
      send(d0); send(d1); send(d2);
    end
    check("frame_cnt", pair_cnt, 4);
    check("frame_done", frame_done, 1);
    check("frame_busy", pack_busy, 0);
    for (int k = 0; k < 13; k++) send(k[0] ? 8'h55 : 8'hAA);
    idle(20);
    check("done_cnt_held", pair_cnt, 4);
    check("done_sticky", frame_done, 1);
    check("done_no_timeout", err_seen - e0, 0);
    check("pending_pairs_b", exp_q.size(), 0);
    do_reset();

    // inter-byte timeout
    e0 = err_seen;
    send(8'h55); send(8'hAA); send(8'h12); send(8'h34);
    found = 1'b0;
    i = 0;
    while (!found && i < 40) begin
      tick();
      i++;
      found = frame_err;
    end
    check("timeout_seen", found, 1);
    check("timeout_latency_ok", 64'(i >= 15 && i <= 17), 1);
    check("timeout_cnt", pair_cnt, 0);
    check("timeout_busy", pack_busy, 0);
    tick();
    check("err_one_cycle", frame_err, 0);
    check("err_count", err_seen - e0, 1);
    // recovery, with bytes landing exactly on the timeout cycle
    send(8'h55); send(8'hAA); idle(15);
    send(8'h9A); idle(15);
    send(8'hBC);
    exp_q.push_back({12'h9AB, 12'hCDE});
    send(8'hDE);
    check("recover_cnt", pair_cnt, 1);
    check("race_no_err", err_seen - e0, 1);
    idle(1);
    check("pending_pairs_c", exp_q.size(), 0);
    do_reset();

    // reset mid-frame
    e0 = err_seen;
    send(8'h55); send(8'hAA);
    exp_q.push_back({12'h111, 12'h222});
    send(8'h11); send(8'h12); send(8'h22);
    exp_q.push_back({12'h333, 12'h444});
    send(8'h33); send(8'h34); send(8'h44);
    send(8'h77); send(8'h88);
    idle(1);
    check("pending_pairs_d", exp_q.size(), 0);
    do_reset();
    check_zero("midframe_reset_outputs");
    send(8'hAA); send(8'h12); send(8'h34); send(8'h56);
    idle(2);
    check("nohdr_cnt", pair_cnt, 0);
    check("nohdr_busy", pack_busy, 0);
    check("reset_no_err", err_seen - e0, 0);
    check("pending_pairs_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
